// File: rtl/approx_seq_multiplier.sv
// approx_seq_multiplier
// Four-step shift-and-add multiplier for 4-bit unsigned operands. Each step's
// addition is done by an external adder, which may be approximate. The adder
// is driven from add_in1/add_in2/add_sel/add_cin and must return add_sum
// combinationally in the same cycle.
//
// Register roles:
//   a_reg   multiplicand, captured at accept
//   u_reg   upper half of the running partial product
//   q_reg   multiplier bits, shifted right each step; the low product
//           bits enter from the top as they are produced
//   s_reg   approximation select, forwarded to the adder unchanged
//   cnt     step counter, 0..3
//
// When ZERO_GATE is set, a step whose multiplier bit is 0 does not use the
// adder at all. Both adder inputs are held at zero, which saves switching,
// and the step result is taken straight from u_reg. Any adder error on
// that step is therefore avoided.

module approx_seq_multiplier #(
    parameter int ZERO_GATE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] sel_cfg,
    output logic [3:0] add_in1,
    output logic [3:0] add_in2,
    output logic [2:0] add_sel,
    output logic       add_cin,
    input  logic [4:0] add_sum,
    output logic [7:0] prod,
    output logic       prod_valid,
    input  logic       prod_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  a_reg;
    logic [3:0]  u_reg;
    logic [3:0]  q_reg;
    logic [2:0]  s_reg;
    logic [1:0]  cnt;

    logic [7:0]  prod_reg;
    logic        prod_valid_reg;

    logic [3:0]  in1_comb;
    logic [3:0]  in2_comb;
    logic [4:0]  step_sum;

    logic        accept;
    logic        handshake;
    logic        last_step;

    // Handshake qualifiers. Each one is only meaningful in its own state, so
    // stray start_valid or prod_ready in the other states has no effect.
    assign accept    = (state == IDLE) && start_valid;
    assign handshake = (state == DONE) && prod_ready;
    assign last_step = (state == RUN) && (cnt == 2'd3);

    // Adder operand selection and step result. Outside RUN the adder inputs
    // are quiet, and step_sum is unused.
    always_comb begin
        in1_comb = 4'd0;
        in2_comb = 4'd0;
        step_sum = 5'd0;
        if (state == RUN) begin
            if (q_reg[0]) begin
                in1_comb = u_reg;
                in2_comb = a_reg;
                step_sum = add_sum;
            end else if (ZERO_GATE == 0) begin
                in1_comb = u_reg;
                in2_comb = 4'd0;
                step_sum = add_sum;
            end else begin
                in1_comb = 4'd0;
                in2_comb = 4'd0;
                step_sum = {1'b0, u_reg};
            end
        end
    end

    // Next-state logic. Each operation is strictly sequential:
    // IDLE -> RUN (four steps) -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset takes priority over every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture at accept, then one shift-and-add step per RUN cycle.
    // The carry-out of each step becomes the top of the new partial product.
    // Its low bit drops into q_reg as the multiplier bits shift out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= 4'd0;
            u_reg <= 4'd0;
            q_reg <= 4'd0;
            s_reg <= 3'd0;
            cnt   <= 2'd0;
        end else if (accept) begin
            a_reg <= a;
            u_reg <= 4'd0;
            q_reg <= b;
            s_reg <= sel_cfg;
            cnt   <= 2'd0;
        end else if (state == RUN) begin
            u_reg <= step_sum[4:1];
            q_reg <= {step_sum[0], q_reg[3:1]};
            cnt   <= cnt + 2'd1;
        end
    end

    // Product register. The final step's result is assembled directly, so
    // prod is valid on the same edge that enters DONE. prod keeps its value
    // after the handshake. Only reset or the next completed operation
    // changes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_reg       <= 8'd0;
            prod_valid_reg <= 1'b0;
        end else if (last_step) begin
            prod_reg       <= {step_sum[4:1], step_sum[0], q_reg[3:1]};
            prod_valid_reg <= 1'b1;
        end else if (handshake) begin
            prod_valid_reg <= 1'b0;
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state == RUN) || (state == DONE);
    assign add_in1     = in1_comb;
    assign add_in2     = in2_comb;
    assign add_sel     = s_reg;
    assign add_cin     = 1'b0;
    assign prod        = prod_reg;
    assign prod_valid  = prod_valid_reg;

endmodule

// File: tb/tb_approx_seq_multiplier.sv
// tb_approx_seq_multiplier
// Self-checking bench. Two instances run side by side: one with
// ZERO_GATE=1 and one with ZERO_GATE=0. Both see the same stimulus, and
// each has its own adder loopback. add_bias adds a constant +1 to the
// loopback to act as a deliberately wrong adder.
// Inputs are driven on the falling edge, and outputs are also sampled there.

module tb_approx_seq_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel_cfg;
    logic       prod_ready;
    logic       add_bias;

    logic       start_ready_g, start_ready_n;
    logic [3:0] add_in1_g, add_in1_n;
    logic [3:0] add_in2_g, add_in2_n;
    logic [2:0] add_sel_g, add_sel_n;
    logic       add_cin_g, add_cin_n;
    logic [4:0] add_sum_g, add_sum_n;
    logic [7:0] prod_g, prod_n;
    logic       prod_valid_g, prod_valid_n;
    logic       busy_g, busy_n;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic       bias;
        logic [7:0] exp_g;
        logic [7:0] exp_n;
    } vec_t;

    vec_t vectors[7];

    // Adder loopback models, exact unless add_bias is set.
    assign add_sum_g = {1'b0, add_in1_g} + {1'b0, add_in2_g} + {4'd0, add_cin_g} + {4'd0, add_bias};
    assign add_sum_n = {1'b0, add_in1_n} + {1'b0, add_in2_n} + {4'd0, add_cin_n} + {4'd0, add_bias};

    approx_seq_multiplier #(.ZERO_GATE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready_g),
        .a(a), .b(b), .sel_cfg(sel_cfg),
        .add_in1(add_in1_g), .add_in2(add_in2_g), .add_sel(add_sel_g), .add_cin(add_cin_g),
        .add_sum(add_sum_g), .prod(prod_g), .prod_valid(prod_valid_g),
        .prod_ready(prod_ready), .busy(busy_g)
    );

    approx_seq_multiplier #(.ZERO_GATE(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready_n),
        .a(a), .b(b), .sel_cfg(sel_cfg),
        .add_in1(add_in1_n), .add_in2(add_in2_n), .add_sel(add_sel_n), .add_cin(add_cin_n),
        .add_sum(add_sum_n), .prod(prod_n), .prod_valid(prod_valid_n),
        .prod_ready(prod_ready), .busy(busy_n)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive all request-side inputs in one go.
    task automatic applyStimulus(input logic sv, input logic [3:0] av, input logic [3:0] bv,
                                 input logic [2:0] sel, input logic pr);
        start_valid = sv;
        a           = av;
        b           = bv;
        sel_cfg     = sel;
        prod_ready  = pr;
    endtask

    // One comparison. Values are compared zero-extended to 8 bits.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full operation with prod_ready held high. Checks per-step adder
    // operands, the latency of prod_valid, the product, and the handshake.
    // After the accept edge, the operand inputs are scrambled and
    // start_valid stays high while the multiplier is busy. Neither may
    // disturb the operation in flight.
    task automatic runVector(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        add_bias = v.bias;
        applyStimulus(1'b1, v.a, v.b, v.sel, 1'b1);
        checkOutput({t, "_start_ready"}, {7'd0, start_ready_g}, 8'd1);
        nextCycle();
        applyStimulus(1'b1, ~v.a, ~v.b, ~v.sel, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_busy_s%0d", t, k), {7'd0, busy_g}, 8'd1);
            checkOutput($sformatf("%s_pvalid_s%0d", t, k), {7'd0, prod_valid_g}, 8'd0);
            checkOutput($sformatf("%s_sel_s%0d", t, k), {5'd0, add_sel_g}, {5'd0, v.sel});
            checkOutput($sformatf("%s_cin_s%0d", t, k), {6'd0, add_cin_g, add_cin_n}, 8'd0);
            checkOutput($sformatf("%s_in2g_s%0d", t, k), {4'd0, add_in2_g}, v.b[k] ? {4'd0, v.a} : 8'd0);
            checkOutput($sformatf("%s_in2n_s%0d", t, k), {4'd0, add_in2_n}, v.b[k] ? {4'd0, v.a} : 8'd0);
            if (!v.b[k]) begin
                checkOutput($sformatf("%s_in1g_gated_s%0d", t, k), {4'd0, add_in1_g}, 8'd0);
            end
            nextCycle();
        end
        checkOutput({t, "_pvalid_g"}, {7'd0, prod_valid_g}, 8'd1);
        checkOutput({t, "_pvalid_n"}, {7'd0, prod_valid_n}, 8'd1);
        checkOutput({t, "_prod_g"}, prod_g, v.exp_g);
        checkOutput({t, "_prod_n"}, prod_n, v.exp_n);
        checkOutput({t, "_ready_in_done"}, {7'd0, start_ready_g}, 8'd0);
        applyStimulus(1'b0, v.a, v.b, v.sel, 1'b1);
        nextCycle();
        checkOutput({t, "_pvalid_after_hs"}, {7'd0, prod_valid_g}, 8'd0);
        checkOutput({t, "_ready_after_hs"}, {7'd0, start_ready_g}, 8'd1);
        checkOutput({t, "_prod_retained"}, prod_g, v.exp_g);
        checkOutput({t, "_add_in_idle"}, {add_in1_g, add_in2_g}, 8'd0);
    endtask

    initial begin
        bit seen;
        bit done;
        checks   = 0;
        failures = 0;
        add_bias = 1'b0;

        // Hand-computed products for the ZERO_GATE=1 and ZERO_GATE=0 instances.
        // With the +1 adder, the results follow the step recurrence. For
        // 1*1, ZERO_GATE=1 gives 0x02, because only step 0 goes through the
        // adder. ZERO_GATE=0 gives 0x10, because every step gains +1. For
        // 3*5 the two instances give 0x14 and 0x1E.
        vectors[0] = '{a: 4'd7,  b: 4'd13, sel: 3'b111, bias: 1'b0, exp_g: 8'h5B, exp_n: 8'h5B};
        vectors[1] = '{a: 4'd15, b: 4'd15, sel: 3'b000, bias: 1'b0, exp_g: 8'd225, exp_n: 8'd225};
        vectors[2] = '{a: 4'd0,  b: 4'd9,  sel: 3'b001, bias: 1'b0, exp_g: 8'd0, exp_n: 8'd0};
        vectors[3] = '{a: 4'd9,  b: 4'd0,  sel: 3'b010, bias: 1'b0, exp_g: 8'd0, exp_n: 8'd0};
        vectors[4] = '{a: 4'd1,  b: 4'd1,  sel: 3'b011, bias: 1'b1, exp_g: 8'h02, exp_n: 8'h10};
        vectors[5] = '{a: 4'd3,  b: 4'd5,  sel: 3'b100, bias: 1'b1, exp_g: 8'h14, exp_n: 8'h1E};
        vectors[6] = '{a: 4'd12, b: 4'd10, sel: 3'b110, bias: 1'b0, exp_g: 8'd120, exp_n: 8'd120};

        // Reset state, checked while rst_n is still low.
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_start_ready", {7'd0, start_ready_g}, 8'd1);
        checkOutput("rst_busy", {6'd0, busy_g, busy_n}, 8'd0);
        checkOutput("rst_prod", prod_g, 8'd0);
        checkOutput("rst_prod_valid", {6'd0, prod_valid_g, prod_valid_n}, 8'd0);
        checkOutput("rst_add_in", {add_in1_g, add_in2_g}, 8'd0);
        checkOutput("rst_add_sel", {5'd0, add_sel_g}, 8'd0);

        // The first vector starts on the very first edge with rst_n high.
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            runVector(vectors[i], i);
        end

        // Backpressure: prod_ready is held low for 3 cycles after
        // prod_valid, while start_valid stays high the whole time.
        add_bias = 1'b0;
        applyStimulus(1'b1, 4'd5, 4'd3, 3'd0, 1'b0);
        nextCycle();
        checkOutput("hold_accepted", {7'd0, busy_g}, 8'd1);
        repeat (4) nextCycle();
        checkOutput("hold_pvalid_first", {7'd0, prod_valid_g}, 8'd1);
        checkOutput("hold_prod_first", prod_g, 8'd15);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            checkOutput($sformatf("hold_prod_c%0d", k), prod_g, 8'd15);
            checkOutput($sformatf("hold_pvalid_c%0d", k), {7'd0, prod_valid_g}, 8'd1);
            checkOutput($sformatf("hold_ready_c%0d", k), {7'd0, start_ready_g}, 8'd0);
        end
        applyStimulus(1'b1, 4'd2, 4'd6, 3'd5, 1'b1);
        nextCycle();
        checkOutput("hold_hs_pvalid", {7'd0, prod_valid_g}, 8'd0);
        checkOutput("hold_hs_ready", {7'd0, start_ready_g}, 8'd1);
        checkOutput("hold_hs_prod", prod_g, 8'd15);
        applyStimulus(1'b1, 4'd2, 4'd6, 3'd5, 1'b0);
        nextCycle();
        checkOutput("hold_next_accept", {7'd0, busy_g}, 8'd1);
        checkOutput("hold_next_ready", {7'd0, start_ready_g}, 8'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            if (prod_valid_g) done = 1'b1;
            else nextCycle();
        end
        checkOutput("hold_next_done", {7'd0, done}, 8'd1);
        checkOutput("hold_next_prod", prod_g, 8'd12);
        checkOutput("hold_next_prod_n", prod_n, 8'd12);
        nextCycle();

        // Reset during the second RUN cycle discards the operation.
        applyStimulus(1'b1, 4'd9, 4'd11, 3'd5, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd9, 4'd11, 3'd5, 1'b1);
        nextCycle();
        rst_n = 1'b0;
        nextCycle();
        checkOutput("midrun_rst_ready", {7'd0, start_ready_g}, 8'd1);
        checkOutput("midrun_rst_prod", prod_g, 8'd0);
        checkOutput("midrun_rst_pvalid", {7'd0, prod_valid_g}, 8'd0);
        checkOutput("midrun_rst_sel", {5'd0, add_sel_g}, 8'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            if (prod_valid_g || prod_valid_n || busy_g) seen = 1'b1;
        end
        checkOutput("midrun_rst_no_stale", {7'd0, seen}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
